// File: rtl/hit_scorer_pkg.sv
// -----------------------------------------------------------------------------
// hit_scorer_pkg
// Shared types and constants for the hit-or-miss judge.
//   state_t    : judge FSM states (IDLE, ARMED, TIMING, RESOLVE, WAIT_CLR,
//                GAMEOVER), also exported through hit_scorer.dbg_state.
//   TOKEN_W    : width of the reaction-time token returned to the randomizer.
//   TOKEN_MISS : token value reported after a miss.
//   TOKEN_MAX  : largest token a hit may report, so a hit never aliases a miss.
//   is_onehot  : true when exactly one bit of an 8-bit pattern is set.
// -----------------------------------------------------------------------------
package hit_scorer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARMED    = 3'd1,
        TIMING   = 3'd2,
        RESOLVE  = 3'd3,
        WAIT_CLR = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam int               TOKEN_W    = 8;
    localparam logic [TOKEN_W-1:0] TOKEN_MISS = 8'hFF;
    localparam logic [TOKEN_W-1:0] TOKEN_MAX  = 8'hFE;

    // v & (v - 1) clears the lowest set bit; zero afterwards means at most one
    // bit was set, and the v != 0 term rules out the empty pattern.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/sw_sync_edge.sv
// -----------------------------------------------------------------------------
// sw_sync_edge
// W-bit two-flop synchronizer followed by toggle ("flip") detection for inputs
// that are asynchronous to clk (slide switches, later the start button).
// Ports:
//   clk  in  1  system clock, rising edge
//   rst  in  1  asynchronous active-low reset; every flop loads 0
//   d    in  W  raw asynchronous inputs
//   flip out W  one-cycle registered pulse per toggled bit
// A toggle first sampled at edge N reaches the second synchronizer stage at
// N+1 and is reported on flip from edge N+2 for exactly one cycle.
// -----------------------------------------------------------------------------
module sw_sync_edge #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] flip
);

    logic [W-1:0] meta;
    logic [W-1:0] sync;
    logic [W-1:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
            flip <= '0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
            // Registered so the downstream FSM sees a clean, glitch-free pulse.
            flip <= sync ^ prev;
        end
    end

endmodule

// File: rtl/hit_scorer.sv
// -----------------------------------------------------------------------------
// hit_scorer
// Judge stage for the hit-or-miss game. Captures a one-hot target LED, watches
// the player's switches for a flip, decides hit or miss, and reports the
// reaction time (in ticks) as a token for the LED randomizer. Keeps score and
// miss count and stops the game after MISS_LIMIT misses.
//
// Parameters:
//   WINDOW_CYCLES  clk cycles a captured target stays judgeable
//   TICK_DIV       clk cycles per reaction-time tick
//   SCORE_W        score counter width
//   MISS_LIMIT     misses that end the game (1..15)
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous active-low reset
//   start        in   1        synchronous new-game request, highest priority
//   led          in   8        target pattern from the randomizer
//   sw           in   8        raw player switches (asynchronous)
//   token        out  8        last reaction time in ticks, 8'hFF after a miss
//   token_valid  out  1        one-cycle pulse when token updates
//   hit          out  1        one-cycle pulse on a hit
//   miss         out  1        one-cycle pulse on a miss
//   score        out  SCORE_W  hits this game, saturating
//   misses       out  4        misses this game
//   game_over    out  1        high while in GAMEOVER
//   streak       out  4        consecutive hits (0 unless the bonus is built)
//   dbg_state    out  3        current FSM state (state_t encoding)
//
// Handshake: token/hit/miss follow a valid-only protocol; token_valid is a
// single-cycle pulse with no ready, and token holds its value between pulses.
//
// Build option: define HIT_SCORER_STREAK_BONUS_EN to enable the streak
// counter and the +2 bonus on every hit that brings streak to a multiple of 4.
// -----------------------------------------------------------------------------
module hit_scorer
    import hit_scorer_pkg::*;
#(
    parameter int WINDOW_CYCLES = 50_000_000,
    parameter int TICK_DIV      = 500_000,
    parameter int SCORE_W       = 8,
    parameter int MISS_LIMIT    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         led,
    input  logic [7:0]         sw,
    output logic [TOKEN_W-1:0] token,
    output logic               token_valid,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         misses,
    output logic               game_over,
    output logic [3:0]         streak,
    output logic [2:0]         dbg_state
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TOKEN_W-1:0] REACT_SAT  = 8'hFF;
    localparam logic [3:0]         MISS_LIM_4 = 4'(MISS_LIMIT);
    localparam logic [3:0]         STREAK_SAT = 4'd15;

    // ------------------------------------------------------------------
    // Switch conditioning
    // ------------------------------------------------------------------
    logic [7:0] flip;

    sw_sync_edge #(
        .W (8)
    ) u_sw_sync_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (sw),
        .flip (flip)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state;
    logic [7:0]         target;
    logic [WIN_W-1:0]   win_cnt;
    logic [DIV_W-1:0]   pre_cnt;
    logic [TOKEN_W-1:0] react;
    logic               rearm;    // last miss came from a new target: skip WAIT_CLR

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Judgement terms, only acted upon in TIMING
    // ------------------------------------------------------------------
    logic               wrong_flip;
    logic               right_flip;
    logic               led_change;
    logic               win_end;
    logic               tick;
    logic [TOKEN_W-1:0] react_next;
    logic [TOKEN_W-1:0] hit_token;
    logic [3:0]         streak_inc;
    logic               bonus;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_hit;
    logic [3:0]         misses_inc;

    always_comb begin
        wrong_flip = |(flip & ~target);
        right_flip = |(flip & target);
        led_change = is_onehot(led) && (led != target);
        win_end    = (win_cnt == WIN_LAST);
        tick       = (pre_cnt == DIV_LAST);

        // The reaction count includes the tick completing in the deciding
        // cycle, so a decision k cycles after capture reports k / TICK_DIV.
        react_next = react;
        if (tick && (react != REACT_SAT)) begin
            react_next = react + 8'd1;
        end
        hit_token = (react_next > TOKEN_MAX) ? TOKEN_MAX : react_next;

`ifdef HIT_SCORER_STREAK_BONUS_EN
        streak_inc = (streak == STREAK_SAT) ? STREAK_SAT : (streak + 4'd1);
        // A saturated streak of 15 is not a multiple of 4, so the bonus stops.
        bonus      = (streak_inc[1:0] == 2'b00);
`else
        streak_inc = 4'd0;
        bonus      = 1'b0;
`endif

        score_sum  = {1'b0, score} + (bonus ? (SCORE_W + 1)'(2) : (SCORE_W + 1)'(1));
        score_hit  = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        misses_inc = misses + 4'd1;
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs. Hit/miss are decided on the edge that
    // enters RESOLVE, so the pulses are high for the whole RESOLVE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            target      <= 8'd0;
            win_cnt     <= '0;
            pre_cnt     <= '0;
            react       <= 8'd0;
            rearm       <= 1'b0;
            token       <= 8'd0;
            token_valid <= 1'b0;
            hit         <= 1'b0;
            miss        <= 1'b0;
            score       <= '0;
            misses      <= 4'd0;
            game_over   <= 1'b0;
            streak      <= 4'd0;
        end else begin
            hit         <= 1'b0;
            miss        <= 1'b0;
            token_valid <= 1'b0;

            if (start) begin
                // Overrides everything, including a resolution this cycle.
                state     <= ARMED;
                score     <= '0;
                misses    <= 4'd0;
                streak    <= 4'd0;
                game_over <= 1'b0;
                rearm     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end

                    ARMED: begin
                        if (is_onehot(led)) begin
                            target  <= led;
                            win_cnt <= '0;
                            pre_cnt <= '0;
                            react   <= 8'd0;
                            state   <= TIMING;
                        end
                    end

                    TIMING: begin
                        win_cnt <= win_cnt + WIN_W'(1);
                        pre_cnt <= tick ? '0 : (pre_cnt + DIV_W'(1));
                        react   <= react_next;

                        if (wrong_flip) begin
                            // A wrong switch beats a correct one in the same cycle.
                            miss        <= 1'b1;
                            token_valid <= 1'b1;
                            token       <= TOKEN_MISS;
                            misses      <= misses_inc;
                            streak      <= 4'd0;
                            rearm       <= 1'b0;
                            state       <= RESOLVE;
                        end else if (right_flip) begin
                            hit         <= 1'b1;
                            token_valid <= 1'b1;
                            token       <= hit_token;
                            score       <= score_hit;
                            streak      <= streak_inc;
                            rearm       <= 1'b0;
                            state       <= RESOLVE;
                        end else if (led_change) begin
                            // The new target is already on led; judge it next.
                            miss        <= 1'b1;
                            token_valid <= 1'b1;
                            token       <= TOKEN_MISS;
                            misses      <= misses_inc;
                            streak      <= 4'd0;
                            rearm       <= 1'b1;
                            state       <= RESOLVE;
                        end else if (win_end || (led == 8'd0)) begin
                            miss        <= 1'b1;
                            token_valid <= 1'b1;
                            token       <= TOKEN_MISS;
                            misses      <= misses_inc;
                            streak      <= 4'd0;
                            rearm       <= 1'b0;
                            state       <= RESOLVE;
                        end
                    end

                    RESOLVE: begin
                        if (misses == MISS_LIM_4) begin
                            state     <= GAMEOVER;
                            game_over <= 1'b1;
                        end else if (rearm) begin
                            state <= ARMED;
                        end else begin
                            state <= WAIT_CLR;
                        end
                    end

                    WAIT_CLR: begin
                        // Hold off until the randomizer blanks the LEDs so the
                        // same target is never judged twice.
                        if (led == 8'd0) begin
                            state <= ARMED;
                        end
                    end

                    GAMEOVER: begin
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hit_scorer.sv
// -----------------------------------------------------------------------------
// tb_hit_scorer
// Directed bench for hit_scorer (WINDOW_CYCLES=100, TICK_DIV=4, MISS_LIMIT=3).
// Two instances share every input: dut (SCORE_W=8) and dut_s (SCORE_W=2) so
// score saturation is seen on the narrow one. Expected outcomes are derived
// from stimulus timing: a decision k cycles after capture reports k/TICK_DIV.
// Streak expectations follow HIT_SCORER_STREAK_BONUS_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_hit_scorer;

    localparam int WIN = 100;
    localparam int DIV = 4;
    localparam int LIM = 3;

    // dbg_state values in declaration order of the state list
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_TIME  = 3'd2;
    localparam logic [2:0] S_OVER  = 3'd5;

    localparam int K_HIT   = 0;
    localparam int K_MISS  = 1;
    localparam int K_START = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [7:0] led = 8'd0;
    logic [7:0] sw = 8'd0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic [7:0] token, s_token;
    logic       token_valid, s_token_valid, hit, s_hit, miss, s_miss;
    logic [7:0] score;
    logic [1:0] s_score;
    logic [3:0] misses, s_misses, streak, s_streak;
    logic       game_over, s_game_over;
    logic [2:0] dbg_state, s_dbg_state;

    hit_scorer #(.WINDOW_CYCLES(WIN), .TICK_DIV(DIV), .SCORE_W(8), .MISS_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .led(led), .sw(sw),
        .token(token), .token_valid(token_valid), .hit(hit), .miss(miss),
        .score(score), .misses(misses), .game_over(game_over), .streak(streak),
        .dbg_state(dbg_state)
    );

    hit_scorer #(.WINDOW_CYCLES(WIN), .TICK_DIV(DIV), .SCORE_W(2), .MISS_LIMIT(LIM)) dut_s (
        .clk(clk), .rst(rst), .start(start), .led(led), .sw(sw),
        .token(s_token), .token_valid(s_token_valid), .hit(s_hit), .miss(s_miss),
        .score(s_score), .misses(s_misses), .game_over(s_game_over), .streak(s_streak),
        .dbg_state(s_dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] tok;
        int         s8;
        int         s2;
        int         mis;
        int         stk;
        bit         go;
    } ev_t;

    ev_t exp_q[$];

    // Model of game bookkeeping, advanced as outcomes are scheduled.
    int m_s8 = 0, m_s2 = 0, m_mis = 0, m_stk = 0;

    function automatic int sat_add(input int s, input int inc, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (s + inc > mx) ? mx : s + inc;
    endfunction

    task automatic push_hit(input int at, input int k);
        ev_t e;
        int inc;
        int t;
        inc = 1;
`ifdef HIT_SCORER_STREAK_BONUS_EN
        m_stk = (m_stk == 15) ? 15 : m_stk + 1;
        if (m_stk % 4 == 0) inc = 2;
`endif
        m_s8 = sat_add(m_s8, inc, 8);
        m_s2 = sat_add(m_s2, inc, 2);
        t = k / DIV;
        if (t > 254) t = 254;
        e.at = at; e.kind = K_HIT; e.tok = t[7:0];
        e.s8 = m_s8; e.s2 = m_s2; e.mis = m_mis; e.stk = m_stk; e.go = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_miss(input int at);
        ev_t e;
        m_mis++;
        m_stk = 0;
        e.at = at; e.kind = K_MISS; e.tok = 8'hFF;
        e.s8 = m_s8; e.s2 = m_s2; e.mis = m_mis; e.stk = 0; e.go = (m_mis == LIM);
        exp_q.push_back(e);
    endtask

    task automatic push_start(input int at);
        ev_t e;
        m_s8 = 0; m_s2 = 0; m_mis = 0; m_stk = 0;
        e.at = at; e.kind = K_START; e.tok = 8'h00;
        e.s8 = 0; e.s2 = 0; e.mis = 0; e.stk = 0; e.go = 1'b0;
        exp_q.push_back(e);
    endtask

    // Compare process: every cycle, outputs must match the scoreboard.
    logic [7:0] cur_tok = 8'd0;
    int cur_s8 = 0, cur_s2 = 0, cur_mis = 0, cur_stk = 0;
    bit cur_go = 1'b0;
    int go_at = -1;

    always @(negedge clk) begin : cmp
        ev_t ev;
        logic eh;
        logic em;
        eh = 1'b0;
        em = 1'b0;
        if (!rst) begin
            exp_q.delete();
            cur_tok = 8'd0; cur_s8 = 0; cur_s2 = 0; cur_mis = 0; cur_stk = 0;
            cur_go = 1'b0; go_at = -1;
        end else begin
            if (go_at == cyc) cur_go = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL event_time: event for cycle %0d still pending at cycle %0d", exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                ev = exp_q.pop_front();
                cur_s8 = ev.s8; cur_s2 = ev.s2; cur_mis = ev.mis; cur_stk = ev.stk;
                if (ev.kind == K_HIT) begin
                    eh = 1'b1; cur_tok = ev.tok;
                end else if (ev.kind == K_MISS) begin
                    em = 1'b1; cur_tok = ev.tok;
                    if (ev.go) go_at = cyc + 1;
                end else begin
                    cur_go = 1'b0; go_at = -1;
                end
            end
        end
        chk("hit", hit, eh);
        chk("miss", miss, em);
        chk("token_valid", token_valid, eh | em);
        chk("token", token, cur_tok);
        chk("score", score, cur_s8);
        chk("misses", misses, cur_mis);
        chk("game_over", game_over, cur_go);
        chk("streak", streak, cur_stk);
        chk("s_hit", s_hit, eh);
        chk("s_miss", s_miss, em);
        chk("s_token_valid", s_token_valid, eh | em);
        chk("s_token", s_token, cur_tok);
        chk("s_score", s_score, cur_s2);
        chk("s_misses", s_misses, cur_mis);
        chk("s_game_over", s_game_over, cur_go);
        chk("s_streak", s_streak, cur_stk);
    end

    // ---------------- driver tasks ----------------
    int cap = 0;           // capture edge of the current target
    logic [7:0] tgt = 8'd0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        if (cyc > t) begin
            n_checks++;
            n_fail++;
            $display("FAIL schedule: at cycle %0d, required <= %0d", cyc, t);
        end
        while (cyc < t) tick(1);
    endtask

    task automatic do_start();
        start = 1'b1;
        push_start(cyc + 1);
        tick(1);
        start = 1'b0;
    endtask

    task automatic arm(input logic [7:0] t);
        led = t;
        tgt = t;
        cap = cyc + 1;
    endtask

    // Toggle mask so the FSM decides exactly k cycles after capture
    // (toggle sampled at N, flip registered at N+2, decision at N+3).
    task automatic flip_at(input logic [7:0] mask, input int k);
        wait_cyc(cap + k - 4);
        sw = sw ^ mask;
        if ((mask & ~tgt) != 8'd0) push_miss(cap + k);
        else push_hit(cap + k, k);
    endtask

    task automatic settle();
        led = 8'd0;
        tick(4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d;
        logic [7:0] tl [5];
        tl[0] = 8'h01; tl[1] = 8'h02; tl[2] = 8'h04; tl[3] = 8'h08; tl[4] = 8'h80;

        #2 rst = 1'b0;
        tick(3);
        chk("reset_state", dbg_state, S_IDLE);
        chk("reset_state_s", s_dbg_state, S_IDLE);
        chk("reset_token", token, 0);
        chk("reset_score", score, 0);
        rst = 1'b1;
        tick(2);

        // hit 40 cycles after capture -> 10 ticks
        do_start();
        chk("start_armed", dbg_state, S_ARMED);
        arm(8'h04);
        flip_at(8'h04, 40);
        wait_cyc(cap + 40);
        chk("hit_pulse", hit, 1);
        chk("hit_token", token, 10);
        chk("hit_score", score, 1);
        settle();

        // wrong switch, then wrong+right on the same edge
        arm(8'h04);
        flip_at(8'h20, 20);
        wait_cyc(cap + 20);
        chk("wrong_miss", miss, 1);
        chk("wrong_token", token, 8'hFF);
        chk("wrong_misses", misses, 1);
        chk("wrong_score", score, 1);
        settle();
        arm(8'h04);
        flip_at(8'h24, 12);
        wait_cyc(cap + 12);
        chk("both_miss", miss, 1);
        chk("both_misses", misses, 2);
        settle();

        // no flip: miss exactly WIN cycles after capture, third miss ends game
        arm(8'h04);
        push_miss(cap + WIN);
        wait_cyc(cap + WIN - 1);
        chk("window_early", miss, 0);
        tick(1);
        chk("window_miss", miss, 1);
        chk("window_misses", misses, 3);
        tick(1);
        chk("game_over", game_over, 1);
        chk("over_state", dbg_state, S_OVER);
        led = 8'h02;
        sw = sw ^ 8'h02;
        tick(20);
        chk("over_stays", dbg_state, S_OVER);
        do_start();
        chk("restart_go", game_over, 0);
        chk("restart_score", score, 0);
        chk("restart_misses", misses, 0);
        chk("restart_state", dbg_state, S_ARMED);
        led = 8'h03;
        tick(10);
        chk("multibit_armed", dbg_state, S_ARMED);
        led = 8'h00;
        tick(2);

        // correct flip on the window's last cycle -> hit, 100/4 ticks
        arm(8'h08);
        flip_at(8'h08, WIN);
        wait_cyc(cap + WIN);
        chk("edge_hit", hit, 1);
        chk("edge_token", token, 25);
        settle();

        // led dropped to 0 -> miss
        arm(8'h10);
        wait_cyc(cap + 29);
        led = 8'h00;
        push_miss(cap + 30);
        wait_cyc(cap + 30);
        chk("drop_miss", miss, 1);
        tick(4);

        // led moved to another target -> miss, re-arm on the new one
        arm(8'h20);
        wait_cyc(cap + 16);
        led = 8'h40;
        d = cap + 17;
        push_miss(d);
        tgt = 8'h40;
        cap = d + 2;
        flip_at(8'h40, 9);
        wait_cyc(cap + 9);
        chk("rearm_hit", hit, 1);
        chk("rearm_token", token, 2);
        settle();

        // streak of hits; narrow score saturates
        do_start();
        for (int i = 0; i < 5; i++) begin
            arm(tl[i]);
            flip_at(tl[i], 8 + 4 * i);
            wait_cyc(cap + 8 + 4 * i);
            if (i == 3) begin
`ifdef HIT_SCORER_STREAK_BONUS_EN
                chk("streak4_score", score, 5);
                chk("streak4", streak, 4);
`else
                chk("streak4_score", score, 4);
                chk("streak4", streak, 0);
`endif
            end
            settle();
        end
        chk("sat_score", s_score, 3);
        arm(8'h01);
        flip_at(8'h02, 10);
        wait_cyc(cap + 10);
        chk("streak_clear", streak, 0);
        settle();

        // reset in the middle of TIMING
        arm(8'h01);
        tick(10);
        chk("pre_rst_timing", dbg_state, S_TIME);
        rst = 1'b0;
        m_s8 = 0; m_s2 = 0; m_mis = 0; m_stk = 0;
        #1;
        chk("rst_async_state", dbg_state, S_IDLE);
        chk("rst_async_token", token, 0);
        tick(3);
        rst = 1'b1;
        led = 8'h04;
        tick(10);
        chk("idle_ignores_led", dbg_state, S_IDLE);
        chk("idle_no_hit", hit, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
